// File: rtl/therm_pkg.sv
// Shared constants and helpers for the thermometer-to-binary decoder.
package therm_pkg;

  localparam int N_DEF         = 8;
  localparam int W_DEF         = 2**N_DEF;
  localparam int ERR_CNT_W_DEF = 16;
  localparam logic [ERR_CNT_W_DEF-1:0] ERR_CNT_MAX = '1;

  // popcount accepts words up to POP_MAX_W bits (N <= 10); callers zero-extend.
  localparam int POP_MAX_W = 1024;

  function automatic int popcount(input logic [POP_MAX_W-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      cnt = cnt + int'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/therm_bubble_fix.sv
// Combinational 3-tap majority filter that repairs isolated single-bit bubbles.
// Bit -1 is treated as 1 and bit W as 0, so legal codes pass through unchanged.
// Only instantiated when THERM_BUBBLE_CORRECT_EN is defined.
module therm_bubble_fix
  import therm_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] fixed
);

  logic [W+1:0] ext;

  assign ext = {1'b0, din, 1'b1};

  // majority of each bit and its two neighbours
  always_comb begin
    fixed = '0;
    for (int i = 0; i < W; i++) begin
      fixed[i] = (ext[i] & ext[i+1]) | (ext[i+1] & ext[i+2]) | (ext[i] & ext[i+2]);
    end
  end

endmodule

// File: rtl/therm_2_bin_pipe.sv
// Two-stage valid/ready thermometer-to-binary decoder with bubble detection
// and a saturating bubble counter. Defining THERM_BUBBLE_CORRECT_EN adds a
// majority filter ahead of the popcount; detection always uses the raw word.
module therm_2_bin_pipe
  import therm_pkg::*;
#(
  parameter  int N         = N_DEF,
  parameter  int ERR_CNT_W = ERR_CNT_W_DEF,
  localparam int W         = 2**N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         din,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N:0]           dout,
  output logic                 bubble_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0] c;
  logic         e;
  logic         s1_v;
  logic [W-1:0] s1_c;
  logic         s1_e;
  logic         s2_v;
  logic         s1_ready;
  logic         s2_ready;
  logic [N:0]   dout_nxt;

`ifdef THERM_BUBBLE_CORRECT_EN
  therm_bubble_fix #(.W(W)) u_fix (
    .din   (din),
    .fixed (c)
  );
`else
  assign c = din;
`endif

  // a one sitting directly above a zero marks a non-monotonic code
  assign e = |(din[W-1:1] & ~din[W-2:0]);

  assign s2_ready  = ~s2_v | out_ready;
  assign s1_ready  = ~s1_v | s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_v;

  // ones-count of the stored S1 word, sized to N+1 bits so W itself fits
  always_comb begin
    dout_nxt = (N+1)'(popcount(POP_MAX_W'(s1_c)));
  end

  // stage 1: capture (possibly corrected) word and raw bubble flag
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v <= 1'b0;
      s1_c <= '0;
      s1_e <= 1'b0;
    end else if (s1_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_c <= c;
        s1_e <= e;
      end
    end
  end

  // stage 2: register the binary result and its bubble flag
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_v       <= 1'b0;
      dout       <= '0;
      bubble_err <= 1'b0;
    end else if (s2_ready) begin
      s2_v <= s1_v;
      if (s1_v) begin
        dout       <= dout_nxt;
        bubble_err <= s1_e;
      end
    end
  end

  // count bubbled words at acceptance, holding at full scale
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (in_valid && s1_ready && e && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: doc/therm_2_bin_pipe.md
Name: therm_2_bin_pipe

Overview:
- Pipelined thermometer-to-binary decoder, the downstream consumer of the binary-to-thermometer stage.
- Takes a 2**N-bit thermometer word with ones packed in the LSBs and returns the ones-count as an (N+1)-bit binary value.
- Detects bubbles (non-monotonic codes) and flags them. When the optional feature is compiled in, it also corrects single-bit bubbles.
- Valid/ready on both sides, full throughput, 2-cycle latency.

Parameters:
- N, 8, binary width; thermometer width W = 2**N.
- ERR_CNT_W, 16, width of the saturating bubble-error counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  din is valid this cycle.
- in_ready  output  1  stage accepts din this cycle.
- din  input  W  thermometer word; a legal code is ones in bits [k-1:0] and zeros above, k in 0..W.
- out_valid  output  1  dout/bubble_err are valid.
- out_ready  input  1  downstream accepts the output.
- dout  output  N+1  ones-count k, range 0..W.
- bubble_err  output  1  the input word for this result was non-monotonic.
- err_cnt  output  ERR_CNT_W  saturating count of accepted words with bubble_err=1.

Behaviour:
- Reset. All pipeline valid bits are 0, so out_valid=0. dout=0, bubble_err=0, err_cnt=0. in_ready=1 in the first cycle after reset.
- Transfers:
  - Input transfer occurs on in_valid & in_ready; output transfer on out_valid & out_ready.
  - din must hold while in_valid=1 & in_ready=0. dout and bubble_err hold stable while out_valid=1 & out_ready=0.
- Pipeline stage S1 (registered):
  - c = corrected word (see Optional Feature).
  - e = OR over i=0..W-2 of (din[i+1] & ~din[i]), always computed on raw din.
- Pipeline stage S2 (registered):
  - dout = popcount(c), N+1 bits; W ones gives dout = W (e.g. 256 for N=8).
  - bubble_err = e.
- Ready chain:
  - s2_ready = ~s2_v | out_ready
  - s1_ready = ~s1_v | s2_ready
  - in_ready = s1_ready (combinational from out_ready; no registered skid).
- Latency: exactly 2 cycles from input transfer to out_valid with no stall. Throughput is 1 word/cycle with out_ready held at 1.
- Stall: when out_ready=0, S2 holds. S1 fills and then holds; in_ready drops after both stages are full. No data is lost or duplicated.
- Simultaneous events: when S2 drains and S1 moves into S2 in the same cycle, S1 also loads a new input if in_valid=1.
- err_cnt:
  - Increments by 1 on every input transfer whose e=1. Counted at S1 load, not at output.
  - Saturates at 2**ERR_CNT_W-1; no wrap.
- Reset mid-operation: in-flight words are discarded, out_valid drops the next cycle, and err_cnt clears.
- Boundary codes: din=0 gives dout=0, bubble_err=0. din=all-ones gives dout=W, bubble_err=0.

Optional Feature:
- Macro: THERM_BUBBLE_CORRECT_EN.
- Defined: the S1 word is a 3-tap majority filter, c[i] = maj(din[i-1], din[i], din[i+1]), with din[-1]=1 and din[W]=0 as boundary values. Isolated single-bit bubbles are repaired before popcount.
- Undefined: c = din, raw popcount.
- bubble_err and err_cnt behave identically in both builds.

Decomposition:
- Package therm_pkg: N default, W derivation, ERR_CNT_W default, ERR_CNT_MAX constant, and a popcount function.
- Sub-module therm_bubble_fix: combinational majority filter, instantiated only under THERM_BUBBLE_CORRECT_EN.
- Pipeline registers, ready chain and counter stay in the top module.

Test Plan:
- Reset, then din = 0x...00FF (8 ones), in_valid pulse, out_ready=1 → out_valid exactly 2 cycles later, dout=8, bubble_err=0, err_cnt=0.
- Back-to-back stream of k=0, 1, 128, 255, 256 (all-ones) → one result per cycle in order: 0, 1, 128, 255, 256; no gaps.
- din = 0x...00F7 (bubble at bit 3, 7 ones):
  - With the macro: dout=8, bubble_err=1, err_cnt=1.
  - Without the macro: dout=7, bubble_err=1.
- out_ready=0 for 5 cycles with in_valid=1 → in_ready drops after 2 accepted words. dout holds stable; after release, all words emerge once, in order.
- ERR_CNT_W=2 with 5 bubbled inputs → err_cnt reads 1, 2, 3, 3, 3 (saturates).
- Assert reset with both stages full → next cycle out_valid=0, err_cnt=0; the first post-reset input yields the correct dout after 2 cycles.
